// File: rtl/vh_result_pkg.sv
// ----------------------------------------------------------------------------
// vh_result_pkg
//
// Shared definitions for the packed expression-result bus {y0..y17}.
//
// The 90-bit word carries 18 fields, y0 in the most significant bits.
// The field layout repeats every three fields:
//   width(k)  = 4 + (k mod 3)  -> 4, 5, 6, 4, 5, 6, ...
//   signed(k) = (k / 3) is odd -> y3-y5, y9-y11 and y15-y17 are signed
// Each group of three fields is 15 bits wide, so 6 groups fill 90 bits.
//
// Contents:
//   VH_NFIELDS, VH_WORD_W, VH_WIN_W   bus geometry
//   vh_fidx_t                         field index type (0..17)
//   vh_state_e                        unpacker FSM states
//   vh_field_w(k), vh_field_signed(k) field map helpers
// ----------------------------------------------------------------------------
package vh_result_pkg;

    localparam int VH_NFIELDS = 18;
    localparam int VH_WORD_W  = 90;
    // Widest field; the extractor always looks at this many top bits.
    localparam int VH_WIN_W   = 6;

    typedef logic [4:0] vh_fidx_t;

    localparam vh_fidx_t VH_LAST_IDX = 5'd17;

    typedef enum logic {
        VH_IDLE = 1'b0,
        VH_BUSY = 1'b1
    } vh_state_e;

    // Bit width of field k.
    function automatic logic [2:0] vh_field_w(input vh_fidx_t k);
        return 3'(4 + (int'(k) % 3));
    endfunction

    // 1 when field k carries a two's-complement value.
    function automatic logic vh_field_signed(input vh_fidx_t k);
        return ((int'(k) / 3) % 2) == 1;
    endfunction

endpackage

// File: rtl/vh_field_ext.sv
// ----------------------------------------------------------------------------
// vh_field_ext
//
// Combinational width/sign extension of one field to OUT_W bits.
// The field occupies the top width_i bits of the 6-bit window (the window is
// the top of the unpacker's shift register), so the field MSB is always
// win_i[5] regardless of the field width.
//
// Ports:
//   win_i     [5:0]       top six bits of the shift register
//   width_i   [2:0]       field width, 4..6
//   signed_i              1: replicate the field MSB, 0: fill with zeros
//   ext_o     [OUT_W-1:0] right-aligned, extended field
//
// Parameters:
//   OUT_W   output width, must be >= 6
// ----------------------------------------------------------------------------
module vh_field_ext #(
    parameter int OUT_W = 8
) (
    input  logic [5:0]       win_i,
    input  logic [2:0]       width_i,
    input  logic             signed_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [5:0]       field;
    logic [OUT_W-1:0] field_wide;
    logic             fill;

    always_comb begin
        // Right-align the field: drop the (6 - width) bits below it.
        field            = win_i >> (3'd6 - width_i);
        field_wide       = '0;
        field_wide[5:0]  = field;
        fill             = signed_i & win_i[5];
        ext_o            = '0;
        for (int i = 0; i < OUT_W; i++) begin
            ext_o[i] = (i < int'(width_i)) ? field_wide[i] : fill;
        end
    end

endmodule

// File: rtl/vh_result_unpacker.sv
// ----------------------------------------------------------------------------
// vh_result_unpacker
//
// Receives one 90-bit packed result word {y0..y17} per in_valid/in_ready
// handshake and emits its 18 fields one per out_valid/out_ready handshake,
// y0 first, each extended to OUT_W bits according to its type.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both 1. The producer holds in_data while in_valid
// is high and not yet accepted; the outputs here hold out_data/out_idx/
// out_signed/out_last stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  word handshake
//   in_data   [89:0]   packed word, y0 = [89:86], y17 = [5:0]
//   out_valid/out_ready field handshake
//   out_data  [OUT_W-1:0] field k, extended
//   out_idx   [4:0]    field index k
//   out_signed         field k is a signed type
//   out_last           k == 17
//   out_sum   [OUT_W-1:0] running sum of the word's extended fields so far
//                      (only when VH_UNPACK_CHECKSUM_EN is defined)
//
// Configuration macro: VH_UNPACK_CHECKSUM_EN adds out_sum and its accumulator.
//
// in_ready depends combinationally on out_ready in the last-field cycle so a
// new word can be latched in the same cycle field 17 leaves (no bubble).
// ----------------------------------------------------------------------------
module vh_result_unpacker
    import vh_result_pkg::*;
#(
    parameter int NFIELDS = 18,
    parameter int OUT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VH_WORD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [4:0]           out_idx,
    output logic                 out_signed,
    output logic                 out_last
`ifdef VH_UNPACK_CHECKSUM_EN
    ,
    output logic [OUT_W-1:0]     out_sum
`endif
);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (NFIELDS != VH_NFIELDS) begin : g_bad_nfields
        $error("vh_result_unpacker: NFIELDS must be 18");
    end
    if (OUT_W < VH_WIN_W) begin : g_bad_out_w
        $error("vh_result_unpacker: OUT_W must be >= 6");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    vh_state_e             state_q, state_d;
    vh_fidx_t              idx_q, idx_d;
    logic [VH_WORD_W-1:0]  shreg_q, shreg_d;
    logic [OUT_W-1:0]      out_data_q;
    logic                  out_signed_q;
    logic                  out_last_q;

    logic                  last_field;
    logic                  take;
    logic                  accept;

    // Field presented next cycle, derived from the next-state values so
    // the output registers line up with idx_q/shreg_q.
    logic [2:0]            nxt_w;
    logic                  nxt_s;
    logic [OUT_W-1:0]      nxt_ext;

    assign last_field = (idx_q == VH_LAST_IDX);
    assign take       = (state_q == VH_BUSY) && out_ready;
    assign in_ready   = (state_q == VH_IDLE) || (take && last_field);
    assign accept     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (accept) begin
            // Covers both a fresh word from IDLE and the zero-bubble
            // hand-over while field 17 leaves.
            state_d = VH_BUSY;
            idx_d   = '0;
            shreg_d = in_data;
        end else if (take) begin
            // Shift the consumed field out of the top of the register.
            shreg_d = shreg_q << vh_field_w(idx_q);
            if (last_field) begin
                state_d = VH_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end
    end

    assign nxt_w = vh_field_w(idx_d);
    assign nxt_s = vh_field_signed(idx_d);

    vh_field_ext #(
        .OUT_W (OUT_W)
    ) u_field_ext (
        .win_i    (shreg_d[VH_WORD_W-1 -: VH_WIN_W]),
        .width_i  (nxt_w),
        .signed_i (nxt_s),
        .ext_o    (nxt_ext)
    );

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= VH_IDLE;
            idx_q        <= '0;
            shreg_q      <= '0;
            out_data_q   <= '0;
            out_signed_q <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            out_data_q   <= nxt_ext;
            out_signed_q <= nxt_s;
            out_last_q   <= (state_d == VH_BUSY) && (idx_d == VH_LAST_IDX);
        end
    end

    assign out_valid  = (state_q == VH_BUSY);
    assign out_idx    = idx_q;
    assign out_data   = out_data_q;
    assign out_signed = out_signed_q;
    assign out_last   = out_last_q;

`ifdef VH_UNPACK_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running checksum: restarts at field 0 of each latched word and adds
    // each following field as it becomes current.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = nxt_ext;
        end else if (take && !last_field) begin
            sum_d = sum_q + nxt_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_sum = sum_q;
`endif

endmodule

// File: tb/tb_vh_result_unpacker.sv
// ----------------------------------------------------------------------------
// tb_vh_result_unpacker
//
// Bench for vh_result_unpacker. A reference model turns every accepted word
// into its 18 expected fields (plain arithmetic on the field map) and queues
// them; the monitor pops one entry per output handshake.
// ----------------------------------------------------------------------------
module tb_vh_result_unpacker;

    localparam int OUT_W = 8;
    localparam int EW    = 23; // {sum[7:0], last, signed, idx[4:0], data[7:0]}

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [89:0] in_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [4:0]  out_idx;
    logic        out_signed;
    logic        out_last;
`ifdef VH_UNPACK_CHECKSUM_EN
    logic [7:0]  out_sum;
`endif

    always #5 clk = ~clk;

    vh_result_unpacker #(
        .NFIELDS (18),
        .OUT_W   (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_signed (out_signed),
        .out_last   (out_last)
`ifdef VH_UNPACK_CHECKSUM_EN
        ,
        .out_sum    (out_sum)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            ntakes = 0;
    int            first_valid_cyc = -1;
    int            last_take_cyc = -1;
    int            rdy_mode = 0; // 0: always ready, 1: toggle, 2: random
    bit            after_rst = 1'b0;
    logic [7:0]    cap_data[18];
    logic          cap_last[18];
    logic [7:0]    cap_sum;
    logic [EW-1:0] e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: slice the word from the top, field by field.
    function automatic void push_word(input logic [89:0] w);
        int pos;
        int sum;
        pos = 90;
        sum = 0;
        for (int k = 0; k < 18; k++) begin
            int wd;
            bit sgn;
            int f;
            int v;
            wd  = 4 + (k % 3);
            sgn = ((k / 3) % 2) == 1;
            pos = pos - wd;
            f   = int'((w >> pos) & ((90'd1 << wd) - 90'd1));
            v   = (sgn && f >= (1 << (wd - 1))) ? f - (1 << wd) : f;
            sum = sum + v;
            exp_q.push_back({8'(sum), (k == 17), sgn, 5'(k), 8'(v)});
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor: samples mid-cycle, the values seen here are the ones the
    // next rising edge will act on.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                check("rst_out_valid",  out_valid,  0);
                check("rst_in_ready",   in_ready,   1);
                check("rst_out_data",   out_data,   0);
                check("rst_out_idx",    out_idx,    0);
                check("rst_out_signed", out_signed, 0);
                check("rst_out_last",   out_last,   0);
`ifdef VH_UNPACK_CHECKSUM_EN
                check("rst_out_sum",    out_sum,    0);
`endif
                after_rst = 1'b0;
            end
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready,
                  (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_field", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data",   out_data,   e[7:0]);
                    check("out_idx",    out_idx,    e[12:8]);
                    check("out_signed", out_signed, e[13]);
                    check("out_last",   out_last,   e[14]);
`ifdef VH_UNPACK_CHECKSUM_EN
                    check("out_sum",    out_sum,    e[22:15]);
                    cap_sum = out_sum;
`endif
                    cap_data[out_idx % 18] = out_data;
                    cap_last[out_idx % 18] = out_last;
                    last_take_cyc = cyc;
                    ntakes++;
                end
            end
            if (in_valid && in_ready) push_word(in_data);
        end
    end

    // ------------------------------------------------------------------
    // Consumer driver
    // ------------------------------------------------------------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Producer driver tasks
    // ------------------------------------------------------------------
    task automatic send_word(input logic [89:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 1000);
        if (n >= 1000) check("drain_timeout", 0, 1);
    endtask

    function automatic logic [89:0] rand_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[89:0];
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int base;
        int n;
        logic [89:0] w;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All-zero word: every field 0, out_last only on field 17.
        rdy_mode = 0;
        send_word(90'd0);
        drain();
        for (int k = 0; k < 18; k++) begin
            check("t1_data", cap_data[k], 0);
            check("t1_last", cap_last[k], (k == 17));
        end

        // All-ones word: unsigned fields saturate to 2^w-1, signed to -1.
        send_word({90{1'b1}});
        drain();
        check("t2_k0", cap_data[0], 8'h0F);
        check("t2_k1", cap_data[1], 8'h1F);
        check("t2_k2", cap_data[2], 8'h3F);
        check("t2_k3", cap_data[3], 8'hFF);
        check("t2_k5", cap_data[5], 8'hFF);
        check("t2_k8", cap_data[8], 8'h3F);
`ifdef VH_UNPACK_CHECKSUM_EN
        check("t2_sum17", cap_sum, 8'h3E);
`endif

        // Single-bit words at both ends of the bus.
        w = 90'd1 << 86;
        send_word(w);
        drain();
        check("t3_k0", cap_data[0], 8'h01);
        for (int k = 1; k < 18; k++) check("t3_rest", cap_data[k], 0);
        send_word(90'h20);
        drain();
        check("t3_k17", cap_data[17], 8'hE0);

        // Toggling out_ready: every field held until taken.
        rdy_mode = 1;
        first_valid_cyc = -1;
        base = ntakes;
        send_word(rand_word());
        drain();
        check("t4_count", ntakes - base, 18);
        n = last_take_cyc - first_valid_cyc + 1;
        check("t4_span", (n >= 35 && n <= 36), 1);

        // Back-to-back words with out_ready=1: no bubble between them.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        first_valid_cyc = -1;
        base = ntakes;
        send_word(rand_word());
        send_word(rand_word());
        drain();
        check("t5_count", ntakes - base, 36);
        check("t5_span", last_take_cyc - first_valid_cyc + 1, 36);

        // Reset mid-word after field 7 has been taken.
        base = ntakes;
        send_word(rand_word());
        n = 0;
        while (ntakes < base + 8 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_reached_k7", ntakes >= base + 8, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = ntakes;
        send_word(rand_word());
        drain();
        check("t6_restart_count", ntakes - base, 18);

        // Random words, random back-pressure, random idle gaps.
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            send_word(rand_word());
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        check("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
